// File: rtl/updown_counter_param.sv
// Up/down counter with step, load and wrap-or-clamp bounds; 1-cycle latency to count and flags.
// No backpressure: inputs are sampled every rising clk edge.
module updown_counter_param #(
    parameter int              WIDTH    = 5,
    parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
    parameter bit              SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             increment,
    input  logic             decrement,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] step,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_zero,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH-1:0] MAX_W   = MAX_EXT[WIDTH-1:0];
    localparam logic [WIDTH:0]   MOD_EXT = MAX_EXT + {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH-1:0] eff_step;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH:0]   count_ext;
    logic [WIDTH:0]   step_ext;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   wrap_up_ext;
    logic [WIDTH:0]   wrap_dn_ext;
    logic [WIDTH-1:0] count_nxt;
    logic             overflow_nxt;
    logic             underflow_nxt;

    assign eff_step     = ({1'b0, step} > MAX_EXT) ? MAX_W : step;
    assign load_clamped = ({1'b0, load_value} > MAX_EXT) ? MAX_W : load_value;

    // All arithmetic is one bit wider than the count so nothing truncates before the bound test.
    assign count_ext   = {1'b0, count};
    assign step_ext    = {1'b0, eff_step};
    assign sum_ext     = count_ext + step_ext;
    assign wrap_up_ext = sum_ext - MOD_EXT;
    assign wrap_dn_ext = count_ext + MOD_EXT - step_ext;

    always_comb begin
        count_nxt     = count;
        overflow_nxt  = 1'b0;
        underflow_nxt = 1'b0;
        if (load) begin
            count_nxt = load_clamped;
        end else if (increment && !decrement && (eff_step != '0)) begin
            if (sum_ext > MAX_EXT) begin
                overflow_nxt = 1'b1;
                count_nxt    = SATURATE ? MAX_W : wrap_up_ext[WIDTH-1:0];
            end else begin
                count_nxt = sum_ext[WIDTH-1:0];
            end
        end else if (decrement && !increment && (eff_step != '0)) begin
            if (count < eff_step) begin
                underflow_nxt = 1'b1;
                count_nxt     = SATURATE ? '0 : wrap_dn_ext[WIDTH-1:0];
            end else begin
                count_nxt = count - eff_step;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count     <= count_nxt;
            overflow  <= overflow_nxt;
            underflow <= underflow_nxt;
        end
    end

    assign at_max  = (count == MAX_W);
    assign at_zero = (count == '0);

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed checks of a wrapping and a clamping counter (WIDTH=5, MAX_VAL=23) driven by shared inputs.
module tb_updown_counter_param;

    logic       clk = 1'b0;
    logic       reset, increment, decrement, load;
    logic [4:0] load_value, step;
    logic [4:0] count_w, count_s;
    logic       at_max_w, at_zero_w, ovf_w, unf_w;
    logic       at_max_s, at_zero_s, ovf_s, unf_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    updown_counter_param #(.WIDTH(5), .MAX_VAL(23), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .reset(reset), .increment(increment), .decrement(decrement),
        .load(load), .load_value(load_value), .step(step),
        .count(count_w), .at_max(at_max_w), .at_zero(at_zero_w),
        .overflow(ovf_w), .underflow(unf_w)
    );

    updown_counter_param #(.WIDTH(5), .MAX_VAL(23), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .reset(reset), .increment(increment), .decrement(decrement),
        .load(load), .load_value(load_value), .step(step),
        .count(count_s), .at_max(at_max_s), .at_zero(at_zero_s),
        .overflow(ovf_s), .underflow(unf_s)
    );

    typedef struct {
        string      name;
        logic       rst, ld, inc, dec;
        logic [4:0] ld_val, stp;
        int         w_cnt; logic w_ovf, w_unf;
        int         s_cnt; logic s_ovf, s_unf;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic l, input logic i, input logic d,
                         input logic [4:0] lv, input logic [4:0] s);
        reset = r; load = l; increment = i; decrement = d; load_value = lv; step = s;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wrap(input string name, input int c, input logic o, input logic u);
        chk({name, " wrap count"}, int'(count_w), c);
        chk({name, " wrap overflow"}, int'(ovf_w), int'(o));
        chk({name, " wrap underflow"}, int'(unf_w), int'(u));
        chk({name, " wrap at_max"}, int'(at_max_w), int'(c == 23));
        chk({name, " wrap at_zero"}, int'(at_zero_w), int'(c == 0));
    endtask

    task automatic chk_sat(input string name, input int c, input logic o, input logic u);
        chk({name, " sat count"}, int'(count_s), c);
        chk({name, " sat overflow"}, int'(ovf_s), int'(o));
        chk({name, " sat underflow"}, int'(unf_s), int'(u));
        chk({name, " sat at_max"}, int'(at_max_s), int'(c == 23));
        chk({name, " sat at_zero"}, int'(at_zero_s), int'(c == 0));
    endtask

    vec_t vecs[$];

    initial begin
        int exp_c;
        reset = 1'b1; load = 1'b0; increment = 1'b0; decrement = 1'b0;
        load_value = '0; step = '0;

        //           name           rst  ld   inc  dec  ldv    stp    wrap: cnt ovf unf  sat: cnt ovf unf
        vecs.push_back('{"reset",     1'b1,1'b0,1'b0,1'b0,5'd0, 5'd0,  0, 1'b0,1'b0,  0, 1'b0,1'b0});
        vecs.push_back('{"load20",    1'b0,1'b1,1'b0,1'b0,5'd20,5'd0, 20, 1'b0,1'b0, 20, 1'b0,1'b0});
        vecs.push_back('{"up5_a",     1'b0,1'b0,1'b1,1'b0,5'd0, 5'd5,  1, 1'b1,1'b0, 23, 1'b1,1'b0});
        vecs.push_back('{"up5_b",     1'b0,1'b0,1'b1,1'b0,5'd0, 5'd5,  6, 1'b0,1'b0, 23, 1'b1,1'b0});
        vecs.push_back('{"dn7",       1'b0,1'b0,1'b0,1'b1,5'd0, 5'd7, 23, 1'b0,1'b1, 16, 1'b0,1'b0});
        vecs.push_back('{"both3",     1'b0,1'b0,1'b1,1'b1,5'd0, 5'd3, 23, 1'b0,1'b0, 16, 1'b0,1'b0});
        vecs.push_back('{"load30inc", 1'b0,1'b1,1'b1,1'b0,5'd30,5'd1, 23, 1'b0,1'b0, 23, 1'b0,1'b0});
        vecs.push_back('{"both1",     1'b0,1'b0,1'b1,1'b1,5'd0, 5'd1, 23, 1'b0,1'b0, 23, 1'b0,1'b0});
        vecs.push_back('{"up0",       1'b0,1'b0,1'b1,1'b0,5'd0, 5'd0, 23, 1'b0,1'b0, 23, 1'b0,1'b0});
        vecs.push_back('{"dn31",      1'b0,1'b0,1'b0,1'b1,5'd0, 5'd31, 0, 1'b0,1'b0,  0, 1'b0,1'b0});
        vecs.push_back('{"dn1_at0",   1'b0,1'b0,1'b0,1'b1,5'd0, 5'd1, 23, 1'b0,1'b1,  0, 1'b0,1'b1});
        vecs.push_back('{"rst_ld7",   1'b1,1'b1,1'b1,1'b0,5'd7, 5'd1,  0, 1'b0,1'b0,  0, 1'b0,1'b0});
        vecs.push_back('{"up31",      1'b0,1'b0,1'b1,1'b0,5'd0, 5'd31,23, 1'b0,1'b0, 23, 1'b0,1'b0});
        vecs.push_back('{"load2",     1'b0,1'b1,1'b0,1'b0,5'd2, 5'd0,  2, 1'b0,1'b0,  2, 1'b0,1'b0});
        vecs.push_back('{"dn5_at2",   1'b0,1'b0,1'b0,1'b1,5'd0, 5'd5, 21, 1'b0,1'b1,  0, 1'b0,1'b1});
        vecs.push_back('{"rst_pend",  1'b1,1'b0,1'b0,1'b1,5'd0, 5'd5,  0, 1'b0,1'b0,  0, 1'b0,1'b0});
        vecs.push_back('{"resume",    1'b0,1'b0,1'b1,1'b0,5'd0, 5'd4,  4, 1'b0,1'b0,  4, 1'b0,1'b0});

        @(posedge clk);
        #1;
        foreach (vecs[k]) begin
            drive(vecs[k].rst, vecs[k].ld, vecs[k].inc, vecs[k].dec, vecs[k].ld_val, vecs[k].stp);
            chk_wrap(vecs[k].name, vecs[k].w_cnt, vecs[k].w_ovf, vecs[k].w_unf);
            chk_sat(vecs[k].name, vecs[k].s_cnt, vecs[k].s_ovf, vecs[k].s_unf);
        end

        // Full lap of the wrapping counter: one overflow pulse, only after the 23->0 edge.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd1);
        chk_wrap("lap reset", 0, 1'b0, 1'b0);
        exp_c = 0;
        for (int i = 0; i < 24; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd1);
            exp_c = (exp_c + 1) % 24;
            chk_wrap($sformatf("lap%0d", i), exp_c, (i == 23), 1'b0);
        end
        // Pulse must last a single cycle even while holding.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd1);
        chk_wrap("lap hold", 0, 1'b0, 1'b0);

        // Zero step with increment held for three cycles changes nothing.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd9, 5'd0);
        chk_wrap("step0 load", 9, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0);
            chk_wrap($sformatf("step0_%0d", i), 9, 1'b0, 1'b0);
            chk_sat($sformatf("step0_%0d", i), 9, 1'b0, 1'b0);
        end

        // Clamp at zero repeats the underflow pulse on each edge.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd3);
            chk_sat($sformatf("sat_dn_at0_%0d", i), 0, 1'b0, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
